// File: rtl/lsb_rs_pkg.sv
// lsb_rs_pkg: shared definitions for the load/store reservation queue.
//   - default widths and depth
//   - memory op-type codes (loads 0..4, stores 5..7)
//   - is_store(): store/load classification of an op-type code
package lsb_rs_pkg;

    localparam int DEPTH_DEF    = 16;
    localparam int ROB_ID_W_DEF = 5;
    localparam int XLEN_DEF     = 32;
    localparam int TYPE_W_DEF   = 5;
    localparam int NUM_CDB_DEF  = 2;

    typedef enum logic [TYPE_W_DEF-1:0] {
        OP_LB  = 5'd0,
        OP_LH  = 5'd1,
        OP_LW  = 5'd2,
        OP_LBU = 5'd3,
        OP_LHU = 5'd4,
        OP_SB  = 5'd5,
        OP_SH  = 5'd6,
        OP_SW  = 5'd7
    } op_type_e;

    function automatic logic is_store(input logic [TYPE_W_DEF-1:0] t);
        return (t == OP_SB) || (t == OP_SH) || (t == OP_SW);
    endfunction

endpackage

// File: rtl/lsb_rs_wakeup.sv
// lsb_rs_wakeup: compares one pending operand tag against all CDB buses.
// Ports:
//   pending     in   operand is waiting on a producer
//   tag         in   producer ROB tag
//   cdb_valid   in   per-bus broadcast valid
//   cdb_rob_id  in   packed bus tags, bus 0 in LSBs
//   cdb_value   in   packed bus values, bus 0 in LSBs
//   hit         out  some valid bus carries the tag
//   value       out  value of the lowest-index matching bus
module lsb_rs_wakeup #(
    parameter int ROB_ID_W = 5,
    parameter int XLEN     = 32,
    parameter int NUM_CDB  = 2
) (
    input  logic                        pending,
    input  logic [ROB_ID_W-1:0]         tag,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]     cdb_value,
    output logic                        hit,
    output logic [XLEN-1:0]             value
);

    // Scan from the highest bus down so the lowest matching index is the
    // last assignment and therefore wins.
    always_comb begin
        hit   = 1'b0;
        value = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (pending && cdb_valid[i] &&
                (cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == tag)) begin
                hit   = 1'b1;
                value = cdb_value[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/lsb_rs_queue.sv
// lsb_rs_queue: in-order reservation queue feeding the load/store buffer.
// Holds DEPTH memory ops, snoops NUM_CDB result buses to resolve the base
// (r1) and store-data (r2) operands, and issues the oldest entry with its
// effective address (r1 + imm) once its operands are resolved.
//
// Optional feature macro: LSB_RS_CDB_BYPASS_EN
//   defined   - dispatch operands matching a same-cycle CDB broadcast are
//               written already resolved with the broadcast value
//   undefined - dispatch operands are stored exactly as presented
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall), clear_in (flush)
//   disp_*        dispatch entry (type, rob id, r1/r2/imm, deps)
//   full_out      no free entry (count == DEPTH)
//   count_out     occupancy
//   cdb_*         packed result buses, bus 0 in LSBs
//   lsb_valid/lsb_ready  issue handshake
//   lsb_type/lsb_rob_id/lsb_addr/lsb_st_value  issued fields (0 when idle)
module lsb_rs_queue
    import lsb_rs_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int XLEN     = XLEN_DEF,
    parameter int TYPE_W   = TYPE_W_DEF,
    parameter int NUM_CDB  = NUM_CDB_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic                        clear_in,
    input  logic                        disp_valid,
    input  logic [TYPE_W-1:0]           disp_type,
    input  logic [ROB_ID_W-1:0]         disp_rob_id,
    input  logic [XLEN-1:0]             disp_r1,
    input  logic [XLEN-1:0]             disp_r2,
    input  logic [XLEN-1:0]             disp_imm,
    input  logic                        disp_has_dep1,
    input  logic                        disp_has_dep2,
    input  logic [ROB_ID_W-1:0]         disp_dep1,
    input  logic [ROB_ID_W-1:0]         disp_dep2,
    output logic                        full_out,
    output logic [$clog2(DEPTH):0]      count_out,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*XLEN-1:0]     cdb_value,
    output logic                        lsb_valid,
    input  logic                        lsb_ready,
    output logic [TYPE_W-1:0]           lsb_type,
    output logic [ROB_ID_W-1:0]         lsb_rob_id,
    output logic [XLEN-1:0]             lsb_addr,
    output logic [XLEN-1:0]             lsb_st_value
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]               e_valid, e_pend1, e_pend2;
    logic [DEPTH-1:0][TYPE_W-1:0]   e_type;
    logic [DEPTH-1:0][ROB_ID_W-1:0] e_rob, e_dep1, e_dep2;
    logic [DEPTH-1:0][XLEN-1:0]     e_r1, e_r2, e_imm;
    logic [PTR_W-1:0]               head, tail;
    logic [CNT_W-1:0]               count;

    logic [DEPTH-1:0]               hit1, hit2;
    logic [DEPTH-1:0][XLEN-1:0]     val1, val2;

    // Per-entry wakeup: one comparator bank per pending operand.
    for (genvar g = 0; g < DEPTH; g++) begin : g_lane
        lsb_rs_wakeup #(.ROB_ID_W(ROB_ID_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) u_wk1 (
            .pending(e_valid[g] & e_pend1[g]), .tag(e_dep1[g]),
            .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
            .hit(hit1[g]), .value(val1[g]));
        lsb_rs_wakeup #(.ROB_ID_W(ROB_ID_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) u_wk2 (
            .pending(e_valid[g] & e_pend2[g]), .tag(e_dep2[g]),
            .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
            .hit(hit2[g]), .value(val2[g]));
    end

    // Operand values/pending bits as they will be written at the tail.
    logic            in_pend1, in_pend2;
    logic [XLEN-1:0] in_r1, in_r2;

`ifdef LSB_RS_CDB_BYPASS_EN
    logic            byp_hit1, byp_hit2;
    logic [XLEN-1:0] byp_val1, byp_val2;

    lsb_rs_wakeup #(.ROB_ID_W(ROB_ID_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) u_byp1 (
        .pending(disp_has_dep1), .tag(disp_dep1),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .hit(byp_hit1), .value(byp_val1));
    lsb_rs_wakeup #(.ROB_ID_W(ROB_ID_W), .XLEN(XLEN), .NUM_CDB(NUM_CDB)) u_byp2 (
        .pending(disp_has_dep2), .tag(disp_dep2),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .hit(byp_hit2), .value(byp_val2));

    assign in_pend1 = disp_has_dep1 & ~byp_hit1;
    assign in_pend2 = disp_has_dep2 & ~byp_hit2;
    assign in_r1    = byp_hit1 ? byp_val1 : disp_r1;
    assign in_r2    = byp_hit2 ? byp_val2 : disp_r2;
`else
    assign in_pend1 = disp_has_dep1;
    assign in_pend2 = disp_has_dep2;
    assign in_r1    = disp_r1;
    assign in_r2    = disp_r2;
`endif

    // Head readiness: loads never wait on operand 2.
    logic head_store, head_ready, do_enq, do_deq;

    assign head_store = is_store(TYPE_W_DEF'(e_type[head]));
    assign head_ready = !e_pend1[head] && (!head_store || !e_pend2[head]);
    assign lsb_valid  = e_valid[head] && head_ready && rdy_in && !clear_in;
    assign do_deq     = lsb_valid && lsb_ready;
    assign do_enq     = disp_valid && !full_out && rdy_in && !clear_in;

    assign full_out  = (count == CNT_W'(DEPTH));
    assign count_out = count;

    assign lsb_type     = lsb_valid ? e_type[head] : '0;
    assign lsb_rob_id   = lsb_valid ? e_rob[head]  : '0;
    assign lsb_addr     = lsb_valid ? (e_r1[head] + e_imm[head]) : '0;
    assign lsb_st_value = (lsb_valid && head_store) ? e_r2[head] : '0;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            e_valid <= '0;
            e_pend1 <= '0;
            e_pend2 <= '0;
            e_type  <= '0;
            e_rob   <= '0;
            e_dep1  <= '0;
            e_dep2  <= '0;
            e_r1    <= '0;
            e_r2    <= '0;
            e_imm   <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                e_valid <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (hit1[i]) begin
                        e_r1[i]    <= val1[i];
                        e_pend1[i] <= 1'b0;
                    end
                    if (hit2[i]) begin
                        e_r2[i]    <= val2[i];
                        e_pend2[i] <= 1'b0;
                    end
                end
                // The tail slot is free whenever do_enq is set, so no wakeup
                // update can collide with this write.
                if (do_enq) begin
                    e_valid[tail] <= 1'b1;
                    e_type[tail]  <= disp_type;
                    e_rob[tail]   <= disp_rob_id;
                    e_r1[tail]    <= in_r1;
                    e_r2[tail]    <= in_r2;
                    e_imm[tail]   <= disp_imm;
                    e_pend1[tail] <= in_pend1;
                    e_pend2[tail] <= in_pend2;
                    e_dep1[tail]  <= disp_dep1;
                    e_dep2[tail]  <= disp_dep2;
                    tail          <= tail + PTR_W'(1);
                end
                if (do_deq) begin
                    e_valid[head] <= 1'b0;
                    head          <= head + PTR_W'(1);
                end
                case ({do_enq, do_deq})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsb_rs_queue.sv
module tb_lsb_rs_queue;
    import lsb_rs_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        disp_valid;
    logic [4:0]  disp_type, disp_rob_id, disp_dep1, disp_dep2;
    logic [31:0] disp_r1, disp_r2, disp_imm;
    logic        disp_has_dep1, disp_has_dep2;
    logic        full_out;
    logic [4:0]  count_out;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_rob_id;
    logic [63:0] cdb_value;
    logic        lsb_valid, lsb_ready;
    logic [4:0]  lsb_type, lsb_rob_id;
    logic [31:0] lsb_addr, lsb_st_value;

    int errors = 0;
    int checks = 0;

    lsb_rs_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_rob_id(disp_rob_id),
        .disp_r1(disp_r1), .disp_r2(disp_r2), .disp_imm(disp_imm),
        .disp_has_dep1(disp_has_dep1), .disp_has_dep2(disp_has_dep2),
        .disp_dep1(disp_dep1), .disp_dep2(disp_dep2),
        .full_out(full_out), .count_out(count_out),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready),
        .lsb_type(lsb_type), .lsb_rob_id(lsb_rob_id),
        .lsb_addr(lsb_addr), .lsb_st_value(lsb_st_value)
    );

    always #5 clk_in = ~clk_in;

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_disp(input logic [4:0] t, input logic [4:0] rob,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm,
                            input logic hd1, input logic [4:0] d1,
                            input logic hd2, input logic [4:0] d2);
        disp_valid = 1'b1; disp_type = t; disp_rob_id = rob;
        disp_r1 = r1; disp_r2 = r2; disp_imm = imm;
        disp_has_dep1 = hd1; disp_dep1 = d1; disp_has_dep2 = hd2; disp_dep2 = d2;
    endtask

    task automatic test_reset;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count_out); end
        checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", full_out); end
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", lsb_valid); end
        checks++; if (lsb_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", lsb_addr); end
        rst_in = 1'b1;
        step;
        lsb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(OP_LW, 5'(i), 32'h40, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
            step;
        end
        disp_valid = 1'b0;
        checks++; if (count_out !== 5'd3) begin errors++; $display("FAIL midrst_fill: got %0d exp 3", count_out); end
        #2 rst_in = 1'b0;
        #1;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL midrst_count: got %0d exp 0", count_out); end
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b exp 0", lsb_valid); end
        step;
        rst_in = 1'b1;
        step;
    endtask

    task automatic test_load_basic;
        lsb_ready = 1'b1;
        set_disp(OP_LW, 5'd1, 32'h1000, 32'hDEAD, 32'h10, 1'b0, 5'd0, 1'b0, 5'd0);
        step;
        disp_valid = 1'b0;
        checks++; if (lsb_valid !== 1'b1) begin errors++; $display("FAIL ld_valid: got %b exp 1", lsb_valid); end
        checks++; if (lsb_addr !== 32'h1010) begin errors++; $display("FAIL ld_addr: got %h exp 1010", lsb_addr); end
        checks++; if (lsb_st_value !== 32'h0) begin errors++; $display("FAIL ld_stval: got %h exp 0", lsb_st_value); end
        checks++; if (lsb_rob_id !== 5'd1) begin errors++; $display("FAIL ld_rob: got %0d exp 1", lsb_rob_id); end
        checks++; if (lsb_type !== 5'd2) begin errors++; $display("FAIL ld_type: got %0d exp 2", lsb_type); end
        step;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL ld_pulse: got %b exp 0", lsb_valid); end
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL ld_count: got %0d exp 0", count_out); end
    endtask

    task automatic test_load_dep2;
        lsb_ready = 1'b1;
        set_disp(OP_LW, 5'd2, 32'h500, 32'h0, 32'h4, 1'b0, 5'd0, 1'b1, 5'd20);
        step;
        disp_valid = 1'b0;
        checks++; if (lsb_valid !== 1'b1) begin errors++; $display("FAIL ld2_valid: got %b exp 1", lsb_valid); end
        checks++; if (lsb_addr !== 32'h504) begin errors++; $display("FAIL ld2_addr: got %h exp 504", lsb_addr); end
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL ld2_count: got %0d exp 0", count_out); end
    endtask

    task automatic test_store_deps;
        lsb_ready = 1'b1;
        set_disp(OP_SW, 5'd5, 32'h0, 32'h0, 32'h8, 1'b1, 5'd3, 1'b1, 5'd4);
        step;
        disp_valid = 1'b0;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL st_wait0: got %b exp 0", lsb_valid); end
        cdb_valid = 2'b10; cdb_rob_id = {5'd3, 5'd0}; cdb_value = {32'h2000, 32'h0};
        step;
        cdb_valid = 2'b00;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL st_wait1: got %b exp 0", lsb_valid); end
        step;
        cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd4}; cdb_value = {32'h0, 32'hAB};
        #1;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL st_nofwd: got %b exp 0", lsb_valid); end
        step;
        cdb_valid = 2'b00;
        checks++; if (lsb_valid !== 1'b1) begin errors++; $display("FAIL st_valid: got %b exp 1", lsb_valid); end
        checks++; if (lsb_addr !== 32'h2008) begin errors++; $display("FAIL st_addr: got %h exp 2008", lsb_addr); end
        checks++; if (lsb_st_value !== 32'hAB) begin errors++; $display("FAIL st_val: got %h exp ab", lsb_st_value); end
        checks++; if (lsb_type !== 5'd7) begin errors++; $display("FAIL st_type: got %0d exp 7", lsb_type); end
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL st_count: got %0d exp 0", count_out); end
    endtask

    task automatic test_multi_cdb;
        lsb_ready = 1'b0;
        set_disp(OP_LW, 5'd6, 32'h0, 32'h0, 32'h20, 1'b1, 5'd7, 1'b0, 5'd0);
        step;
        disp_valid = 1'b0;
        cdb_valid = 2'b11; cdb_rob_id = {5'd7, 5'd7}; cdb_value = {32'h200, 32'h100};
        step;
        cdb_valid = 2'b00;
        checks++; if (lsb_valid !== 1'b1) begin errors++; $display("FAIL multi_valid: got %b exp 1", lsb_valid); end
        checks++; if (lsb_addr !== 32'h120) begin errors++; $display("FAIL multi_lowbus: got %h exp 120", lsb_addr); end
        lsb_ready = 1'b1;
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL multi_count: got %0d exp 0", count_out); end
    endtask

    task automatic test_fill_wrap;
        lsb_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_disp(OP_LW, 5'(i), 32'h100, 32'h0, 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
            step;
        end
        set_disp(OP_LW, 5'd31, 32'h900, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        step;
        disp_valid = 1'b0;
        checks++; if (count_out !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d exp 16", count_out); end
        checks++; if (full_out !== 1'b1) begin errors++; $display("FAIL fill_full: got %b exp 1", full_out); end
        lsb_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (lsb_valid !== 1'b1 || lsb_rob_id !== 5'(i)) begin errors++; $display("FAIL drain_rob[%0d]: got v=%b rob=%0d exp v=1 rob=%0d", i, lsb_valid, lsb_rob_id, i); end
            checks++; if (lsb_addr !== 32'(32'h100 + i)) begin errors++; $display("FAIL drain_addr[%0d]: got %h exp %h", i, lsb_addr, 32'h100 + i); end
            step;
        end
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d exp 0", count_out); end
        checks++; if (full_out !== 1'b0) begin errors++; $display("FAIL drain_full: got %b exp 0", full_out); end
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b exp 0", lsb_valid); end
    endtask

    task automatic test_in_order;
        lsb_ready = 1'b1;
        set_disp(OP_SW, 5'd10, 32'h0, 32'h55, 32'h4, 1'b1, 5'd9, 1'b0, 5'd0);
        step;
        set_disp(OP_LW, 5'd11, 32'h800, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        step;
        disp_valid = 1'b0;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL ord_block: got %b exp 0", lsb_valid); end
        checks++; if (count_out !== 5'd2) begin errors++; $display("FAIL ord_count: got %0d exp 2", count_out); end
        step;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL ord_block2: got %b exp 0", lsb_valid); end
        cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd9}; cdb_value = {32'h0, 32'h3000};
        step;
        cdb_valid = 2'b00;
        checks++; if (lsb_valid !== 1'b1 || lsb_rob_id !== 5'd10) begin errors++; $display("FAIL ord_st: got v=%b rob=%0d exp v=1 rob=10", lsb_valid, lsb_rob_id); end
        checks++; if (lsb_addr !== 32'h3004 || lsb_st_value !== 32'h55) begin errors++; $display("FAIL ord_st_data: got %h/%h exp 3004/55", lsb_addr, lsb_st_value); end
        step;
        checks++; if (lsb_valid !== 1'b1 || lsb_rob_id !== 5'd11) begin errors++; $display("FAIL ord_ld: got v=%b rob=%0d exp v=1 rob=11", lsb_valid, lsb_rob_id); end
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL ord_count_end: got %0d exp 0", count_out); end
    endtask

    task automatic test_stall;
        lsb_ready = 1'b1;
        rdy_in = 1'b0;
        set_disp(OP_LW, 5'd12, 32'h40, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL stall_noenq: got %0d exp 0", count_out); end
        rdy_in = 1'b1;
        step;
        disp_valid = 1'b0;
        checks++; if (count_out !== 5'd1 || lsb_valid !== 1'b1) begin errors++; $display("FAIL stall_enq: got cnt=%0d v=%b exp cnt=1 v=1", count_out, lsb_valid); end
        rdy_in = 1'b0;
        #1;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b exp 0", lsb_valid); end
        step;
        checks++; if (count_out !== 5'd1) begin errors++; $display("FAIL stall_hold: got %0d exp 1", count_out); end
        rdy_in = 1'b1;
        #1;
        checks++; if (lsb_valid !== 1'b1 || lsb_addr !== 32'h40) begin errors++; $display("FAIL stall_resume: got v=%b addr=%h exp v=1 addr=40", lsb_valid, lsb_addr); end
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL stall_count: got %0d exp 0", count_out); end
    endtask

    task automatic test_clear;
        lsb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_disp(OP_LW, 5'(20 + i), 32'(16 * i), 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
            step;
        end
        disp_valid = 1'b0;
        checks++; if (count_out !== 5'd5 || lsb_valid !== 1'b1) begin errors++; $display("FAIL clr_pre: got cnt=%0d v=%b exp cnt=5 v=1", count_out, lsb_valid); end
        clear_in = 1'b1;
        lsb_ready = 1'b1;
        set_disp(OP_LW, 5'd30, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        checks++; if (lsb_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b exp 0", lsb_valid); end
        step;
        clear_in = 1'b0; disp_valid = 1'b0; lsb_ready = 1'b0;
        checks++; if (count_out !== 5'd0 || lsb_valid !== 1'b0) begin errors++; $display("FAIL clr_post: got cnt=%0d v=%b exp cnt=0 v=0", count_out, lsb_valid); end
        set_disp(OP_LW, 5'd25, 32'h700, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        step;
        disp_valid = 1'b0;
        checks++; if (lsb_valid !== 1'b1 || lsb_rob_id !== 5'd25 || lsb_addr !== 32'h700) begin errors++; $display("FAIL clr_reuse: got v=%b rob=%0d addr=%h exp v=1 rob=25 addr=700", lsb_valid, lsb_rob_id, lsb_addr); end
        lsb_ready = 1'b1;
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL clr_count: got %0d exp 0", count_out); end
    endtask

    task automatic test_dispatch_cdb;
        lsb_ready = 1'b1;
        set_disp(OP_LW, 5'd13, 32'h0, 32'h0, 32'h4, 1'b1, 5'd14, 1'b0, 5'd0);
        cdb_valid = 2'b01; cdb_rob_id = {5'd0, 5'd14}; cdb_value = {32'h0, 32'h900};
        step;
        disp_valid = 1'b0; cdb_valid = 2'b00;
`ifdef LSB_RS_CDB_BYPASS_EN
        checks++; if (lsb_valid !== 1'b1 || lsb_addr !== 32'h904) begin errors++; $display("FAIL byp_issue: got v=%b addr=%h exp v=1 addr=904", lsb_valid, lsb_addr); end
`else
        checks++; if (lsb_valid !== 1'b0 || count_out !== 5'd1) begin errors++; $display("FAIL nobyp_wait: got v=%b cnt=%0d exp v=0 cnt=1", lsb_valid, count_out); end
        cdb_valid = 2'b01;
        step;
        cdb_valid = 2'b00;
        checks++; if (lsb_valid !== 1'b1 || lsb_addr !== 32'h904) begin errors++; $display("FAIL nobyp_issue: got v=%b addr=%h exp v=1 addr=904", lsb_valid, lsb_addr); end
`endif
        step;
        checks++; if (count_out !== 5'd0) begin errors++; $display("FAIL dcdb_count: got %0d exp 0", count_out); end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; lsb_ready = 1'b0;
        disp_valid = 1'b0; disp_type = '0; disp_rob_id = '0;
        disp_r1 = '0; disp_r2 = '0; disp_imm = '0;
        disp_has_dep1 = 1'b0; disp_has_dep2 = 1'b0; disp_dep1 = '0; disp_dep2 = '0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_value = '0;
        step;
        step;
        test_reset;
        test_load_basic;
        test_load_dep2;
        test_store_deps;
        test_multi_cdb;
        test_fill_wrap;
        test_in_order;
        test_stall;
        test_clear;
        test_dispatch_cdb;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsb_rs_queue.md
# lsb_rs_queue

Parametrised, in-order reservation queue between dispatch and the load/store buffer. It holds up to DEPTH memory ops, snoops NUM_CDB result buses to resolve base-address and store-data dependencies, and issues the oldest entry once its operands are resolved. Issue carries the computed effective address (r1 + imm) and the store value. It generalises the fixed two-CDB, fixed-depth load/store RS with configurable depth and CDB count, age-ordered issue with a valid/ready handshake, and occupancy reporting.

## Interface
- DEPTH, 16, queue entries; power of two, ≥2
- ROB_ID_W, 5, ROB tag width
- XLEN, 32, data/address width
- TYPE_W, 5, op-type code width
- NUM_CDB, 2, snooped result buses
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global stall; low freezes all state
- clear_in  in  1  pipeline flush
- disp_valid  in  1  dispatch entry present
- disp_type  in  TYPE_W  op code
- disp_rob_id  in  ROB_ID_W  destination ROB tag
- disp_r1 / disp_r2 / disp_imm  in  XLEN each  base, store data, offset
- disp_has_dep1 / disp_has_dep2  in  1 each  operand pending
- disp_dep1 / disp_dep2  in  ROB_ID_W each  producer tags
- full_out  out  1  no free entry
- count_out  out  $clog2(DEPTH)+1  occupancy
- cdb_valid  in  NUM_CDB  per-bus broadcast valid
- cdb_rob_id  in  NUM_CDB*ROB_ID_W  packed tags, bus 0 in LSBs
- cdb_value  in  NUM_CDB*XLEN  packed values
- lsb_valid  out  1  head issuable
- lsb_ready  in  1  LSB accepts
- lsb_type / lsb_rob_id / lsb_addr / lsb_st_value  out  issued fields

## Operation
- Circular buffer: head, tail pointers ($clog2(DEPTH) bits, wrap naturally), count register.
- Enqueue at tail when disp_valid && !full_out && rdy_in && !clear_in. disp_valid while full: dropped (upstream must gate).
- Wakeup: every valid entry, each pending operand compared against every CDB bus; match captures value, clears pending bit. Multiple matching buses: lowest index wins.
- Head issuable when valid and both operands resolved; loads ignore operand 2 dependency.
- lsb_addr = r1 + imm, truncated mod 2^XLEN. lsb_st_value = r2 (zero for loads).
- Transfer on lsb_valid && lsb_ready at rising edge: head advances, count decrements.
- Simultaneous enqueue and issue: count unchanged; allowed when full only if issuing? No — full_out is registered-count based, so enqueue blocked at count==DEPTH regardless.
- clear_in: next edge head=tail=count=0, all valid bits cleared; same-cycle dispatch and issue suppressed.
- rdy_in low: no state change, lsb_valid forced 0.

## Timing
- Reset: count 0, full_out 0, lsb_valid 0, all lsb_* data outputs 0, all entries invalid.
- full_out = (count == DEPTH); count_out = count; both from registers.
- lsb_valid = head valid && head ready && rdy_in && !clear_in; data outputs combinational from head entry, 0 when lsb_valid low.
- Dispatch with no deps at edge t → earliest lsb_valid in cycle t+1.
- CDB match at edge t → operand resolved, head issuable cycle t+1; no CDB-to-issue forwarding.
- lsb_valid, once high, holds with stable data until accepted unless clear_in or rdy_in low.

## Configuration
- LSB_RS_CDB_BYPASS_EN defined: dispatch operands whose dep tag matches a valid CDB in the dispatch cycle are written resolved with the CDB value.
- Undefined: dispatch operands stored as given; rename stage is required to resolve same-cycle broadcasts before dispatch.

## Structure
- Shared package lsb_rs_pkg: op-type codes (LB, LH, LW, LBU, LHU, SB, SH, SW), is_store function, default widths.
- One sub-module lsb_rs_wakeup: one operand vs NUM_CDB buses, outputs hit and captured value; instantiated 2×DEPTH (+2 with bypass).

## Test plan
- Reset mid-stream with 3 entries: count_out 0, lsb_valid 0 immediately.
- Dispatch LW r1=0x1000, imm=0x10, no deps, lsb_ready=1 → next cycle lsb_addr=0x1010, lsb_valid=1, one-cycle pulse.
- SW dep1=3, dep2=4; CDB bus1 tag 3 value 0x2000, later bus0 tag 4 value 0xAB → issues cycle after second broadcast, addr=0x2000+imm, st_value=0xAB.
- Fill DEPTH entries, lsb_ready=0 → full_out=1, extra dispatch dropped; release → FIFO-order issue, pointer wrap verified.
- Older store blocked, younger load ready → no issue until store resolves (in-order).
- clear_in with 5 entries while lsb_valid=1 → lsb_valid 0 same cycle, count_out 0 next cycle.
